imu_i2c_responder: RTL and testbench

- I2C target (responder) that presents IMU samples through an MPU-style register map, clocked from CLOCK_50.
- It is the far end of the bus that IMUInterface drives as initiator.
- Used for closed-loop benches of the IMU path and for exporting live filtered/raw IMU data to an external I2C master.
- Oversampled design: SCL/SDA are synchronised and edge-detected, with no SCL-clocked logic.

---
 rtl/imu_i2c_pkg.sv | 45 ++++
 rtl/imu_i2c_responder_bus_monitor.sv | 50 +++++
 rtl/imu_i2c_responder.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_imu_i2c_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imu_i2c_pkg.sv
// Shared types for the IMU I2C responder: FSM states, register map and STATUS bits.
`timescale 1ns/1ps
package imu_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam int NUM_SAMPLES = 6;
    localparam int SAMPLE_W    = 10;

    localparam logic [3:0] REG_WHOAMI    = 4'h0;
    localparam logic [3:0] REG_STATUS    = 4'h1;
    localparam logic [3:0] REG_ACCEL_X_H = 4'h2;
    localparam logic [3:0] REG_ACCEL_X_L = 4'h3;
    localparam logic [3:0] REG_ACCEL_Y_H = 4'h4;
    localparam logic [3:0] REG_ACCEL_Y_L = 4'h5;
    localparam logic [3:0] REG_ACCEL_Z_H = 4'h6;
    localparam logic [3:0] REG_ACCEL_Z_L = 4'h7;
    localparam logic [3:0] REG_GYRO_X_H  = 4'h8;
    localparam logic [3:0] REG_GYRO_X_L  = 4'h9;
    localparam logic [3:0] REG_GYRO_Y_H  = 4'hA;
    localparam logic [3:0] REG_GYRO_Y_L  = 4'hB;
    localparam logic [3:0] REG_GYRO_Z_H  = 4'hC;
    localparam logic [3:0] REG_GYRO_Z_L  = 4'hD;
    localparam logic [3:0] REG_CTRL      = 4'hE;

    localparam int STATUS_NEW_SAMPLE = 0;
    localparam int STATUS_OVERRUN    = 1;

    // High byte of a 10-bit signed sample, sign-extended across the top six bits.
    function automatic logic [7:0] sample_hi_byte(input logic [1:0] top_bits);
        return {{6{top_bits[1]}}, top_bits};
    endfunction

endpackage

// File: rtl/imu_i2c_responder_bus_monitor.sv
// Oversampling I2C bus monitor: synchronises SCL/SDA and turns them into
// single-cycle START, STOP, SCL-rise and SCL-fall events plus the settled SDA level.
`timescale 1ns/1ps
module i2c_bus_monitor #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    localparam int STAGES = (SyncStages < 2) ? 2 : SyncStages;

    logic [STAGES-1:0] scl_sync_reg;
    logic [STAGES-1:0] sda_sync_reg;
    logic              scl_prev_reg;
    logic              sda_prev_reg;
    logic              scl_now;
    logic              sda_now;

    // Reset to the idle-bus level so release from reset never looks like a START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[STAGES-2:0], scl_pin};
            sda_sync_reg <= {sda_sync_reg[STAGES-2:0], sda_pin};
            scl_prev_reg <= scl_now;
            sda_prev_reg <= sda_now;
        end
    end

    assign scl_now   = scl_sync_reg[STAGES-1];
    assign sda_now   = sda_sync_reg[STAGES-1];
    assign sda_bit   = sda_now;
    assign scl_rise  = scl_now & ~scl_prev_reg;
    assign scl_fall  = ~scl_now & scl_prev_reg;
    assign start_det = scl_now & scl_prev_reg & sda_prev_reg & ~sda_now;
    assign stop_det  = scl_now & scl_prev_reg & ~sda_prev_reg & sda_now;

endmodule

// File: rtl/imu_i2c_responder.sv
// I2C target exposing IMU samples through an MPU-style register map.
// Optional bus-stall timeout is compiled in with `define I2C_TIMEOUT_EN.
`timescale 1ns/1ps
module imu_i2c_responder
    import imu_i2c_pkg::*;
#(
    parameter logic [6:0] DeviceAddress = 7'h68,
    parameter logic [7:0] WhoAmI        = 8'h68,
    parameter int         SyncStages    = 2,
    parameter int         TimeoutCycles = 500000
) (
    input  logic       CLOCK_50,
    input  logic       Reset_n,
    input  logic [9:0] AccelX,
    input  logic [9:0] AccelY,
    input  logic [9:0] AccelZ,
    input  logic [9:0] GyroX,
    input  logic [9:0] GyroY,
    input  logic [9:0] GyroZ,
    input  logic       SampleValid,
    input  logic       I2C_SCL_in,
    input  logic       I2C_SDA_in,
    output logic       I2C_SDA_oe,
    output logic [7:0] Ctrl,
    output logic       BusActive,
    output logic       ReadDone
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
    logic timeout_hit;

    i2c_bus_monitor #(.SyncStages(SyncStages)) u_monitor (
        .clk       (CLOCK_50),
        .rst_n     (Reset_n),
        .scl_pin   (I2C_SCL_in),
        .sda_pin   (I2C_SDA_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_bit   (sda_bit)
    );

    i2c_state_t state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] shift_reg, shift_next;
    logic [7:0] tx_reg, tx_next;
    logic [3:0] ptr_reg, ptr_next;
    logic [7:0] ctrl_reg, ctrl_next;
    logic       rw_reg, rw_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       bus_active_reg, bus_active_next;
    logic       read_any_reg, read_any_next;
    logic       read_done_reg, read_done_next;
    logic [1:0] status_reg, status_next, status_base;
    logic [1:0] snap_status_reg, snap_status_next;
    logic [7:0] snap_ctrl_reg, snap_ctrl_next;
    logic       snap_take;
    logic [7:0] rx_byte;
    logic [7:0] snap_byte;

    logic [SAMPLE_W-1:0] sample_in   [NUM_SAMPLES];
    logic [SAMPLE_W-1:0] snap_sample [NUM_SAMPLES];

    assign sample_in = '{AccelX, AccelY, AccelZ, GyroX, GyroY, GyroZ};

    // Per-axis shadow (live) and snapshot (frozen for the current read burst).
    for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_sample
        logic [SAMPLE_W-1:0] shadow_reg;
        logic [SAMPLE_W-1:0] snap_reg;

        always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
            if (!Reset_n) begin
                shadow_reg <= '0;
                snap_reg   <= '0;
            end else begin
                if (SampleValid) shadow_reg <= sample_in[gi];
                if (snap_take)   snap_reg   <= shadow_reg;
            end
        end

        assign snap_sample[gi] = snap_reg;
    end

`ifdef I2C_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TimeoutCycles + 1);
    logic [TIMER_W-1:0] timer_reg;

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n)
            timer_reg <= '0;
        else if (!bus_active_reg || scl_rise || scl_fall || timeout_hit)
            timer_reg <= '0;
        else
            timer_reg <= timer_reg + 1'b1;
    end

    assign timeout_hit = bus_active_reg && (timer_reg == TIMER_W'(TimeoutCycles));
`else
    // Without the watchdog the limit is meaningless; a zero limit still never fires.
    assign timeout_hit = (TimeoutCycles < 0);
`endif

    always_comb begin
        snap_byte = 8'h00;
        case (ptr_reg)
            REG_WHOAMI:    snap_byte = WhoAmI;
            REG_STATUS:    snap_byte = {6'b0, snap_status_reg};
            REG_ACCEL_X_H: snap_byte = sample_hi_byte(snap_sample[0][9:8]);
            REG_ACCEL_X_L: snap_byte = snap_sample[0][7:0];
            REG_ACCEL_Y_H: snap_byte = sample_hi_byte(snap_sample[1][9:8]);
            REG_ACCEL_Y_L: snap_byte = snap_sample[1][7:0];
            REG_ACCEL_Z_H: snap_byte = sample_hi_byte(snap_sample[2][9:8]);
            REG_ACCEL_Z_L: snap_byte = snap_sample[2][7:0];
            REG_GYRO_X_H:  snap_byte = sample_hi_byte(snap_sample[3][9:8]);
            REG_GYRO_X_L:  snap_byte = snap_sample[3][7:0];
            REG_GYRO_Y_H:  snap_byte = sample_hi_byte(snap_sample[4][9:8]);
            REG_GYRO_Y_L:  snap_byte = snap_sample[4][7:0];
            REG_GYRO_Z_H:  snap_byte = sample_hi_byte(snap_sample[5][9:8]);
            REG_GYRO_Z_L:  snap_byte = snap_sample[5][7:0];
            REG_CTRL:      snap_byte = snap_ctrl_reg;
            default:       snap_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        tx_next         = tx_reg;
        ptr_next        = ptr_reg;
        ctrl_next       = ctrl_reg;
        rw_next         = rw_reg;
        sda_oe_next     = sda_oe_reg;
        bus_active_next = bus_active_reg;
        read_any_next   = read_any_reg;
        read_done_next  = 1'b0;
        snap_take       = 1'b0;
        rx_byte         = {shift_reg, sda_bit};

        if (start_det) begin
            state_next      = ADDR;
            bit_cnt_next    = 3'd0;
            sda_oe_next     = 1'b0;
            bus_active_next = 1'b1;
        end else if (stop_det) begin
            state_next      = IDLE;
            sda_oe_next     = 1'b0;
            bus_active_next = 1'b0;
            read_done_next  = read_any_reg;
            read_any_next   = 1'b0;
        end else if (timeout_hit) begin
            state_next      = IDLE;
            sda_oe_next     = 1'b0;
            bus_active_next = 1'b0;
            read_any_next   = 1'b0;
        end else begin
            case (state_reg)
                ADDR, REG, WDATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte[6:0];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (state_reg == ADDR) begin
                                if (rx_byte[7:1] == DeviceAddress) begin
                                    rw_next    = rx_byte[0];
                                    state_next = ADDR_ACK;
                                end else begin
                                    state_next = WAIT_STOP;
                                end
                            end else if (state_reg == REG) begin
                                ptr_next   = rx_byte[3:0];
                                state_next = REG_ACK;
                            end else begin
                                if (ptr_reg == REG_CTRL) ctrl_next = rx_byte;
                                ptr_next   = ptr_reg + 4'd1;
                                state_next = WDATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall drives the ACK, the next one releases it.
                ADDR_ACK, REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                            if (state_reg == ADDR_ACK && rw_reg) snap_take = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 3'd0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                state_next  = RDATA;
                                sda_oe_next = ~snap_byte[7];
                                tx_next     = {snap_byte[6:0], 1'b0};
                            end else if (state_reg == ADDR_ACK) begin
                                state_next = REG;
                            end else begin
                                state_next = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_oe_next = ~tx_reg[7];
                        tx_next     = {tx_reg[6:0], 1'b0};
                    end else if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            ptr_next      = ptr_reg + 4'd1;
                            read_any_next = 1'b1;
                            state_next    = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next = 1'b0;
                    end else if (scl_rise) begin
                        bit_cnt_next = 3'd0;
                        if (sda_bit) begin
                            state_next = WAIT_STOP;
                        end else begin
                            state_next = RDATA;
                            tx_next    = snap_byte;
                        end
                    end
                end
                default: ;
            endcase
        end

        // A sample landing with the snapshot counts against the freshly cleared STATUS.
        status_base = snap_take ? 2'b00 : status_reg;
        status_next = status_base;
        if (SampleValid) begin
            status_next[STATUS_NEW_SAMPLE] = 1'b1;
            status_next[STATUS_OVERRUN]    = status_base[STATUS_OVERRUN] | status_base[STATUS_NEW_SAMPLE];
        end
        snap_status_next = snap_take ? status_reg : snap_status_reg;
        snap_ctrl_next   = snap_take ? ctrl_reg   : snap_ctrl_reg;
    end

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 7'd0;
            tx_reg          <= 8'h00;
            ptr_reg         <= 4'h0;
            ctrl_reg        <= 8'h00;
            rw_reg          <= 1'b0;
            sda_oe_reg      <= 1'b0;
            bus_active_reg  <= 1'b0;
            read_any_reg    <= 1'b0;
            read_done_reg   <= 1'b0;
            status_reg      <= 2'b00;
            snap_status_reg <= 2'b00;
            snap_ctrl_reg   <= 8'h00;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_reg       <= shift_next;
            tx_reg          <= tx_next;
            ptr_reg         <= ptr_next;
            ctrl_reg        <= ctrl_next;
            rw_reg          <= rw_next;
            sda_oe_reg      <= sda_oe_next;
            bus_active_reg  <= bus_active_next;
            read_any_reg    <= read_any_next;
            read_done_reg   <= read_done_next;
            status_reg      <= status_next;
            snap_status_reg <= snap_status_next;
            snap_ctrl_reg   <= snap_ctrl_next;
        end
    end

    assign I2C_SDA_oe = sda_oe_reg;
    assign Ctrl       = ctrl_reg;
    assign BusActive  = bus_active_reg;
    assign ReadDone   = read_done_reg;

endmodule

// File: tb/tb_imu_i2c_responder.sv
// Bit-banged I2C master driving imu_i2c_responder; read bytes are checked
// against a scoreboard queue filled when each read is requested.
`timescale 1ns/1ps
module tb_imu_i2c_responder;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
    logic       sample_valid;
    logic       scl;
    logic       sda_drv;
    logic       sda_oe;
    logic [7:0] ctrl;
    logic       bus_active;
    logic       read_done;
    logic       sda_line;

    int vectors     = 0;
    int miscompares = 0;
    int read_done_cnt = 0;
    int oe_cycles     = 0;
    logic [7:0] exp_q[$];

    always #10 clk = ~clk;
    assign sda_line = sda_drv & ~sda_oe;

    imu_i2c_responder dut (
        .CLOCK_50    (clk),
        .Reset_n     (rst_n),
        .AccelX      (accel_x),
        .AccelY      (accel_y),
        .AccelZ      (accel_z),
        .GyroX       (gyro_x),
        .GyroY       (gyro_y),
        .GyroZ       (gyro_z),
        .SampleValid (sample_valid),
        .I2C_SCL_in  (scl),
        .I2C_SDA_in  (sda_line),
        .I2C_SDA_oe  (sda_oe),
        .Ctrl        (ctrl),
        .BusActive   (bus_active),
        .ReadDone    (read_done)
    );

    always @(negedge clk) begin
        if (read_done) read_done_cnt++;
        if (sda_oe) oe_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        sda_drv = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; wait_clk(Q);
        scl = 1'b1;  wait_clk(2 * Q);
        scl = 1'b0;  wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_clk(Q);
        scl = 1'b1;     wait_clk(Q);
        b = sda_line;   wait_clk(Q);
        scl = 1'b0;     wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(data[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            data[i] = b;
        end
        write_bit(~master_ack);
    endtask

    // Pointer write, left open so the caller can follow with STOP, data or a repeated START.
    task automatic set_ptr(input logic [7:0] ptr);
        logic ack_n;
        i2c_start();
        write_byte(8'hD0, ack_n); check_eq("ack_addr_w", ack_n, 0);
        write_byte(ptr, ack_n);   check_eq("ack_ptr", ack_n, 0);
    endtask

    task automatic write_reg(input logic [7:0] ptr, input logic [7:0] data);
        logic ack_n;
        set_ptr(ptr);
        write_byte(data, ack_n); check_eq("ack_wdata", ack_n, 0);
        i2c_stop();
        wait_clk(8);
        $display("txn write reg %02h <= %02h", ptr, data);
    endtask

    task automatic read_txn(input int n, input string tag);
        logic       ack_n;
        logic [7:0] data;
        i2c_start();
        write_byte(8'hD1, ack_n); check_eq("ack_addr_r", ack_n, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(i != n - 1, data);
            if (exp_q.size() == 0) check_eq({tag, "_sb_empty"}, 1, 0);
            else                   check_eq(tag, data, exp_q.pop_front());
        end
        i2c_stop();
        wait_clk(8);
        $display("txn read %0d byte(s) last=%02h (%s)", n, data, tag);
    endtask

    task automatic pulse_sample();
        sample_valid = 1'b1; wait_clk(1);
        sample_valid = 1'b0; wait_clk(1);
    endtask

    initial begin
        logic ack_n;
        int   rd_before, oe_before;

        rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b1; sample_valid = 1'b0;
        accel_x = '0; accel_y = 10'h155; accel_z = '0;
        gyro_x = '0; gyro_y = '0; gyro_z = 10'h1FF;
        wait_clk(5);
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_ctrl", ctrl, 8'h00);
        check_eq("rst_bus_active", bus_active, 0);
        check_eq("rst_read_done", read_done, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // WhoAmI from the reset pointer
        rd_before = read_done_cnt;
        i2c_start();
        check_eq("bus_active_after_start", bus_active, 1);
        write_byte(8'hD1, ack_n); check_eq("ack_addr_r", ack_n, 0);
        exp_q.push_back(8'h68);
        begin
            logic [7:0] d;
            read_byte(1'b0, d);
            check_eq("whoami", d, exp_q.pop_front());
        end
        i2c_stop();
        wait_clk(8);
        $display("txn read whoami");
        check_eq("read_done_pulses", read_done_cnt - rd_before, 1);
        check_eq("bus_active_idle", bus_active, 0);

        // Negative AccelX through pointer write + repeated START
        accel_x = 10'h3F6;
        pulse_sample();
        set_ptr(8'h02);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF6);
        rd_before = read_done_cnt;
        read_txn(2, "accel_x");
        check_eq("read_done_pulses2", read_done_cnt - rd_before, 1);

        // STATUS: two samples set NewSample+Overrun, read clears it
        pulse_sample();
        pulse_sample();
        set_ptr(8'h01);
        exp_q.push_back(8'h03);
        read_txn(1, "status_overrun");
        set_ptr(8'h01);
        exp_q.push_back(8'h00);
        read_txn(1, "status_cleared");

        // Ctrl write, then a discarded write to a read-only register
        write_reg(8'h0E, 8'hA5);
        check_eq("ctrl_written", ctrl, 8'hA5);
        write_reg(8'h03, 8'h55);
        check_eq("ctrl_kept", ctrl, 8'hA5);
        set_ptr(8'h03);
        exp_q.push_back(8'hF6);
        read_txn(1, "accel_x_lo_kept");

        // Upper pointer bits ignored; burst wraps 0x0F -> 0x00
        pulse_sample();
        set_ptr(8'hFE);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h68);
        exp_q.push_back(8'h01);
        read_txn(4, "burst_wrap");
        exp_q.push_back(8'hFF);
        read_txn(1, "ptr_after_burst");

        // Foreign address: never touch SDA
        oe_before = oe_cycles;
        i2c_start();
        write_byte(8'hA0, ack_n); check_eq("nack_foreign", ack_n, 1);
        write_byte(8'h00, ack_n); check_eq("nack_foreign_data", ack_n, 1);
        i2c_stop();
        wait_clk(8);
        $display("txn foreign address 0x50");
        check_eq("oe_foreign", oe_cycles - oe_before, 0);

        // Reset while driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'hD0 >> i));
        check_eq("ack_driven", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ack_oe", sda_oe, 0);
        wait_clk(3);
        scl = 1'b1; sda_drv = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        $display("txn reset mid-ack");
        check_eq("ctrl_after_reset", ctrl, 8'h00);
        check_eq("bus_after_reset", bus_active, 0);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
